simon_playback_seq: RTL and testbench
=====================================

// Module: simon_playback_seq
// PURPOSE
//  Pattern-playback sequencer for the Simon Says game.
//  On a start request it reads the stored colour sequence out of the pattern memory,
//  one entry at a time from address 0, and blinks the matching LED for each entry.
//  It signals done when the sequence has been shown.
//  The game FSM uses it in the blink phase and waits for done before accepting player input.
// PARAMETERS
//  DEPTH       10          pattern memory entries; max sequence length
//  ADDR_W      4           pattern memory address width; must satisfy 2**ADDR_W >= DEPTH
//  SYM_W       2           bits per stored symbol (4 colours)
//  ON_CYCLES   25_000_000  clock cycles an LED stays lit per symbol; must be >= 1
//  OFF_CYCLES  12_500_000  dark clock cycles after each symbol; must be >= 1
// PORTS
//  CLOCK_50    in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high
//  start       in   1       playback request, sampled only in IDLE
//  abort       in   1       cancel playback, synchronous
//  seq_len     in   ADDR_W  number of symbols to play, latched at start
//  mem_rd_en   out  1       pattern memory read strobe
//  mem_addr    out  ADDR_W  pattern memory read address
//  mem_data    in   SYM_W   memory read data, valid 1 cycle after mem_rd_en
//  led         out  4       one-hot colour output: symbol s drives led[s]
//  busy        out  1       high in every state except IDLE
//  done        out  1       single-cycle completion pulse
// BEHAVIOUR
//  Reset
//   - Asserting reset forces IDLE immediately.
//   - All outputs go to 0: led, busy, done, mem_rd_en, mem_addr; index and timer also clear to 0.
//   - Reset mid-playback ends playback with no done pulse.
//  States: IDLE, FETCH, WAIT_DATA, ON, OFF, DONE.
//  IDLE
//   - start=1 latches len = min(seq_len, DEPTH) and sets idx=0.
//   - Next state is FETCH, or DONE if len==0 (no memory read is issued).
//  FETCH (1 cycle)
//   - mem_rd_en=1, mem_addr=idx; next state WAIT_DATA.
//  WAIT_DATA (1 cycle)
//   - Captures mem_data into the symbol register; loads timer=ON_CYCLES-1; next state ON.
//  ON (ON_CYCLES cycles)
//   - led = 1 << symbol.
//   - At timer==0: load timer=OFF_CYCLES-1, next state OFF; otherwise decrement the timer.
//  OFF (OFF_CYCLES cycles)
//   - led = 0.
//   - At timer==0: if idx==len-1 go to DONE, else idx++ and go to FETCH.
//  DONE (1 cycle)
//   - done=1, busy=0; next state IDLE.
//  Timing
//   - Per-symbol period P = 2 + ON_CYCLES + OFF_CYCLES.
//   - If start is accepted at edge 0, done is high in cycle 1 + len*P.
//   - The first LED lights in cycle 3.
//  Outputs and priority
//   - Outputs are decoded from registered state and registers only; no input-to-output comb paths.
//   - start while busy is ignored; seq_len changes while busy are ignored.
//   - abort in any non-IDLE state: next state IDLE, led=0, mem_rd_en=0, no done pulse.
//   - abort has priority over timer expiry and the DONE transition.
//   - start and abort in the same IDLE cycle: abort wins, so start is not accepted.
//   - mem_addr holds its last value outside FETCH and is meaningful only while mem_rd_en=1.
// TESTING (ON_CYCLES=3, OFF_CYCLES=2, so P=7; start pulsed at cycle 0)
//  1. mem[0]=2'b10, seq_len=1
//     -> mem_rd_en=1 with addr 0 at cycle 1;
//     -> led=4'b0100 in cycles 3-5, led=0 in cycles 6-7;
//     -> done=1 only in cycle 8.
//  2. mem={0:2,1:2,2:0}, seq_len=3
//     -> led shows 0100, 0100, 0001 starting in cycles 3, 10 and 17;
//     -> mem_addr is 0, 1, 2 in cycles 1, 8, 15;
//     -> done in cycle 22.
//  3. seq_len=0 -> done in cycle 1; mem_rd_en never asserted; led stays 0.
//  4. seq_len=15 -> clamped to 10: addresses 0-9 read, done in cycle 71, no read at addr>=10.
//  5. Abort and ignored start:
//     -> start re-pulsed at cycle 4 is ignored;
//     -> abort at cycle 4 gives led=0 and busy=0 in cycle 5;
//     -> done is never pulsed; a new start afterwards plays normally.
//  6. reset asserted asynchronously mid-way through cycle 4 (during ON)
//     -> led, busy and done are 0 before the next clock edge;
//     -> after release, state is IDLE and the next start behaves as in test 1.

Source files
------------

// File: rtl/simon_playback_seq_if.sv
// Bundle between the Simon game controller, its pattern memory and the playback sequencer.
// The master side drives requests and memory read data; the slave side is the sequencer.
interface simon_playback_seq_if #(
  parameter int ADDR_W = 4,
  parameter int SYM_W  = 2
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] seq_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [SYM_W-1:0]  mem_data;
  logic [3:0]        led;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, seq_len, mem_data,
    input  mem_rd_en, mem_addr, led, busy, done
  );

  modport slave (
    input  start, abort, seq_len, mem_data,
    output mem_rd_en, mem_addr, led, busy, done
  );
endinterface

// File: rtl/simon_playback_seq.sv
// Simon Says pattern playback: reads the stored colour sequence from address 0 and
// blinks one LED per symbol (ON_CYCLES lit, OFF_CYCLES dark), then pulses done.
module simon_playback_seq #(
  parameter int DEPTH      = 10,
  parameter int ADDR_W     = 4,
  parameter int SYM_W      = 2,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  simon_playback_seq_if.slave bus
);

  localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  // One extra bit so a full-depth length is representable even when DEPTH == 2**ADDR_W.
  localparam int LEN_W   = ADDR_W + 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [LEN_W-1:0] DEPTH_C  = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_ON        = 3'd3,
    ST_OFF       = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  function automatic logic [3:0] sym_to_led(input logic [SYM_W-1:0] sym);
    sym_to_led = 4'b0001 << sym;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [ADDR_W-1:0] req);
    logic [LEN_W-1:0] req_ext;
    req_ext = {1'b0, req};
    if (req_ext > DEPTH_C) begin
      clamp_len = DEPTH_C;
    end else begin
      clamp_len = req_ext;
    end
  endfunction

  state_t             state_r, state_nxt_s;
  logic [LEN_W-1:0]   len_r, len_nxt_s;
  logic [ADDR_W-1:0]  idx_r, idx_nxt_s;
  logic [TMR_W-1:0]   tmr_r, tmr_nxt_s;
  logic [SYM_W-1:0]   sym_r, sym_nxt_s;
  logic [LEN_W-1:0]   start_len_s;
  logic               last_s;

  logic [3:0]         led_r, led_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               rd_en_r, rd_en_nxt_s;
  logic [ADDR_W-1:0]  addr_r, addr_nxt_s;

  assign start_len_s = clamp_len(bus.seq_len);
  assign last_s      = ({1'b0, idx_r} == (len_r - LEN_W'(1)));

  // Next-state, counter and symbol update; abort overrides every transition out of IDLE.
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    idx_nxt_s   = idx_r;
    tmr_nxt_s   = tmr_r;
    sym_nxt_s   = sym_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          len_nxt_s = start_len_s;
          idx_nxt_s = {ADDR_W{1'b0}};
          if (start_len_s == {LEN_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        sym_nxt_s   = bus.mem_data;
        tmr_nxt_s   = ON_LOAD;
        state_nxt_s = ST_ON;
      end
      ST_ON: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          tmr_nxt_s   = OFF_LOAD;
          state_nxt_s = ST_OFF;
        end else begin
          tmr_nxt_s   = tmr_r - TMR_W'(1);
        end
      end
      ST_OFF: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          if (last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s   = idx_r + ADDR_W'(1);
            state_nxt_s = ST_FETCH;
          end
        end else begin
          tmr_nxt_s = tmr_r - TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (bus.abort && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Output values for the coming cycle, decoded from the next state so outputs stay registered.
  always_comb begin
    led_nxt_s   = 4'b0000;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    rd_en_nxt_s = 1'b0;
    addr_nxt_s  = addr_r;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_FETCH: begin
        busy_nxt_s  = 1'b1;
        rd_en_nxt_s = 1'b1;
        addr_nxt_s  = idx_nxt_s;
      end
      ST_WAIT_DATA: begin
        busy_nxt_s = 1'b1;
      end
      ST_ON: begin
        busy_nxt_s = 1'b1;
        led_nxt_s  = sym_to_led(sym_nxt_s);
      end
      ST_OFF: begin
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      len_r   <= {LEN_W{1'b0}};
      idx_r   <= {ADDR_W{1'b0}};
      tmr_r   <= {TMR_W{1'b0}};
      sym_r   <= {SYM_W{1'b0}};
      led_r   <= 4'b0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      idx_r   <= idx_nxt_s;
      tmr_r   <= tmr_nxt_s;
      sym_r   <= sym_nxt_s;
      led_r   <= led_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      rd_en_r <= rd_en_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  assign bus.led       = led_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.mem_rd_en = rd_en_r;
  assign bus.mem_addr  = addr_r;

endmodule

// File: tb/tb_simon_playback_seq.sv
// Directed bench for simon_playback_seq with ON_CYCLES=3, OFF_CYCLES=2 (period 7).
// Cycle k is the clock period that follows active edge k-1; start is sampled at edge 0.
module tb_simon_playback_seq;

  localparam int DEPTH  = 10;
  localparam int ADDR_W = 4;
  localparam int SYM_W  = 2;
  localparam int ON_C   = 3;
  localparam int OFF_C  = 2;
  localparam int P      = 2 + ON_C + OFF_C;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  logic [SYM_W-1:0] mem [16];

  simon_playback_seq_if #(.ADDR_W(ADDR_W), .SYM_W(SYM_W)) bus ();

  simon_playback_seq #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYM_W(SYM_W),
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read pattern memory: data is valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_data <= mem[bus.mem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sl);
    @(negedge clk);
    bus.seq_len = ADDR_W'(sl);
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
  endtask

  // Plays one sequence and checks every output cycle by cycle against the period formula.
  task automatic run_playback(input int sl, input string tag);
    int n, dcyc, i, k;
    logic [3:0] exp_led;
    logic       exp_rd;
    n    = (sl > DEPTH) ? DEPTH : sl;
    dcyc = 1 + n * P;
    pulse_start(sl);
    for (int cyc = 1; cyc <= dcyc + 2; cyc++) begin
      if (cyc > 1) next_cycle();
      i = (cyc - 1) / P;
      k = (cyc - 1) % P;
      exp_rd  = (i < n) && (k == 0);
      exp_led = ((i < n) && (k >= 2) && (k <= 4)) ? (4'b0001 << mem[i]) : 4'b0000;
      total_cnt++;
      if (bus.led !== exp_led) $display("FAIL %s led cyc=%0d got=%b exp=%b", tag, cyc, bus.led, exp_led);
      else pass_cnt++;
      total_cnt++;
      if (bus.mem_rd_en !== exp_rd) $display("FAIL %s rd_en cyc=%0d got=%b exp=%b", tag, cyc, bus.mem_rd_en, exp_rd);
      else pass_cnt++;
      if (exp_rd) begin
        total_cnt++;
        if (bus.mem_addr !== ADDR_W'(i)) $display("FAIL %s addr cyc=%0d got=%0d exp=%0d", tag, cyc, bus.mem_addr, i);
        else pass_cnt++;
      end
      total_cnt++;
      if (bus.done !== (cyc == dcyc)) $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, bus.done, (cyc == dcyc));
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== (cyc < dcyc)) $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, bus.busy, (cyc < dcyc));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.seq_len = '0;
    next_cycle();
    next_cycle();
    total_cnt++;
    if ({bus.led, bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr} !== 12'h000)
      $display("FAIL reset_outputs got=%h exp=000", {bus.led, bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_idle busy got=%b exp=0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_single();
    mem[0] = 2'b10;
    run_playback(1, "single");
  endtask

  task automatic test_multi();
    mem[0] = 2'd2; mem[1] = 2'd2; mem[2] = 2'd0;
    run_playback(3, "multi");
  endtask

  task automatic test_empty();
    run_playback(0, "empty");
  endtask

  task automatic test_clamp();
    for (int a = 0; a < 16; a++) mem[a] = SYM_W'(a % 4);
    run_playback(15, "clamp");
  endtask

  task automatic test_ignore_start();
    mem[0] = 2'd3;
    pulse_start(1);
    for (int cyc = 2; cyc <= 4; cyc++) next_cycle();
    total_cnt++;
    if (bus.led !== 4'b1000) $display("FAIL ignore_start led got=%b exp=1000", bus.led);
    else pass_cnt++;
    bus.start = 1'b1; bus.seq_len = 4'd5;
    next_cycle();
    bus.start = 1'b0;
    for (int cyc = 6; cyc <= 8; cyc++) next_cycle();
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL ignore_start done cyc=8 got=%b exp=1", bus.done);
    else pass_cnt++;
    for (int cyc = 9; cyc <= 14; cyc++) begin
      next_cycle();
      total_cnt++;
      if ({bus.busy, bus.mem_rd_en, bus.done} !== 3'b000)
        $display("FAIL ignore_start idle cyc=%0d got=%b exp=000", cyc, {bus.busy, bus.mem_rd_en, bus.done});
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    mem[0] = 2'd1;
    pulse_start(3);
    next_cycle();
    next_cycle();
    total_cnt++;
    if (bus.led !== 4'b0010) $display("FAIL abort pre_led got=%b exp=0010", bus.led);
    else pass_cnt++;
    next_cycle();
    bus.start = 1'b1; bus.seq_len = 4'd2; bus.abort = 1'b1;
    next_cycle();
    bus.start = 1'b0; bus.abort = 1'b0;
    total_cnt++;
    if ({bus.led, bus.busy, bus.done} !== 6'b000000)
      $display("FAIL abort cyc5 got=%b exp=000000", {bus.led, bus.busy, bus.done});
    else pass_cnt++;
    for (int cyc = 6; cyc <= 25; cyc++) begin
      next_cycle();
      total_cnt++;
      if ({bus.done, bus.mem_rd_en, bus.busy} !== 3'b000)
        $display("FAIL abort after cyc=%0d got=%b exp=000", cyc, {bus.done, bus.mem_rd_en, bus.busy});
      else pass_cnt++;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.seq_len = 4'd1;
    next_cycle();
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if ({bus.busy, bus.mem_rd_en, bus.done} !== 3'b000)
        $display("FAIL abort_vs_start c=%0d got=%b exp=000", c, {bus.busy, bus.mem_rd_en, bus.done});
      else pass_cnt++;
      next_cycle();
    end
    mem[0] = 2'b10;
    run_playback(1, "after_abort");
  endtask

  task automatic test_reset_mid();
    mem[0] = 2'b10;
    pulse_start(1);
    for (int cyc = 2; cyc <= 4; cyc++) next_cycle();
    total_cnt++;
    if (bus.led !== 4'b0100) $display("FAIL reset_mid pre_led got=%b exp=0100", bus.led);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.led, bus.busy, bus.done, bus.mem_rd_en} !== 7'b0000000)
      $display("FAIL reset_mid async got=%b exp=0000000", {bus.led, bus.busy, bus.done, bus.mem_rd_en});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      total_cnt++;
      if ({bus.busy, bus.done, bus.led} !== 6'b000000)
        $display("FAIL reset_mid idle c=%0d got=%b exp=000000", c, {bus.busy, bus.done, bus.led});
      else pass_cnt++;
    end
    run_playback(1, "after_reset");
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.seq_len = '0;
    for (int a = 0; a < 16; a++) mem[a] = '0;
    test_reset();
    test_single();
    test_multi();
    test_empty();
    test_clamp();
    test_ignore_start();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
